// File: rtl/vasip_isa_pkg.sv
// Vector-ASIP instruction-set definitions shared by the encoder and the decoder:
// opcode enumeration, word field positions and opcode classification helpers.
package vasip_isa_pkg;

   typedef enum logic [3:0] {
      OP_INCRI = 4'b0000,
      OP_INCRJ = 4'b0001,
      OP_SETN  = 4'b0010,
      OP_SUMFV = 4'b0011,
      OP_MULFV = 4'b0100,
      OP_NOP   = 4'b0101,
      OP_LDV   = 4'b0110
   } opcode_e;

   localparam int OP_MSB = 31;
   localparam int OP_LSB = 28;
   localparam int IMM_W  = 25;

   localparam logic [31:0] NOP_WORD = 32'h5000_0000;

   // Opcodes are dense from 0, so everything above LDV is illegal.
   function automatic logic is_legal_op(input logic [3:0] op);
      return (op <= OP_LDV);
   endfunction

   function automatic logic is_vec_arith(input logic [3:0] op);
      return (op == OP_SUMFV) || (op == OP_MULFV);
   endfunction

   // Only SETN carries an immediate; every other op gets a zero low field.
   function automatic logic [31:0] encode_word(input logic [3:0] op, input logic [IMM_W-1:0] imm);
      logic [31:0] word;
      word                = '0;
      word[OP_MSB:OP_LSB] = op;
      if (op == OP_SETN) begin
         word[IMM_W-1:0] = imm;
      end
      return word;
   endfunction

endpackage

// File: rtl/instr_encoder_fifo.sv
// Show-ahead FIFO (DEPTH x WIDTH) for encoded instruction words; head is valid
// whenever empty=0, and full/empty are derived from the occupancy counter.
module instr_fifo #(
   parameter int DEPTH = 4,
   parameter int WIDTH = 32
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       push,
   input  logic [WIDTH-1:0]           push_data,
   input  logic                       pop,
   output logic [WIDTH-1:0]           head,
   output logic                       full,
   output logic                       empty,
   output logic [$clog2(DEPTH):0]     level
);

   localparam int AW = $clog2(DEPTH);
   localparam int LW = AW + 1;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr_reg;
   logic [AW-1:0]    rd_ptr_reg;
   logic [LW-1:0]    level_reg;
   logic             do_push;
   logic             do_pop;

   assign full    = (level_reg == LW'(DEPTH));
   assign empty   = (level_reg == '0);
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;
   assign head    = mem[rd_ptr_reg];
   assign level   = level_reg;

   // Storage carries no reset; only the pointers and count define validity.
   always_ff @(posedge clk) begin
      if (do_push) begin
         mem[wr_ptr_reg] <= push_data;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_reg <= '0;
         rd_ptr_reg <= '0;
         level_reg  <= '0;
      end else begin
         if (do_push) begin
            wr_ptr_reg <= wr_ptr_reg + AW'(1);
         end
         if (do_pop) begin
            rd_ptr_reg <= rd_ptr_reg + AW'(1);
         end
         case ({do_push, do_pop})
            2'b10:   level_reg <= level_reg + LW'(1);
            2'b01:   level_reg <= level_reg - LW'(1);
            default: level_reg <= level_reg;
         endcase
      end
   end

endmodule

// File: rtl/instr_encoder.sv
// Instruction-word producer: encodes op/imm requests, queues them in instr_fifo and
// issues them on a valid/ready port. Define INSTR_ENC_NOP_PAD_EN for hazard NOP padding.
module instr_encoder
   import vasip_isa_pkg::*;
#(
   parameter int DEPTH   = 4,
   parameter int NOP_GAP = 2
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    in_valid,
   output logic                    in_ready,
   input  logic [3:0]              in_op,
   input  logic [24:0]             in_imm,
   output logic                    instr_valid,
   input  logic                    instr_ready,
   output logic [31:0]             instr,
   output logic [$clog2(DEPTH):0]  level,
   output logic                    err_illegal,
   input  logic                    err_clr
);

   logic        accept;
   logic        op_legal;
   logic        fifo_push;
   logic        fifo_pop;
   logic        fifo_full;
   logic        fifo_empty;
   logic [31:0] fifo_head;
   logic [31:0] enc_word;
   logic        err_set;
   logic        err_reg;
   logic        err_next;

   assign in_ready  = !fifo_full;
   assign accept    = in_valid && in_ready;
   assign op_legal  = is_legal_op(in_op);
   assign fifo_push = accept && op_legal;
   assign err_set   = accept && !op_legal;
   assign enc_word  = encode_word(in_op, in_imm);

   instr_fifo #(
      .DEPTH (DEPTH),
      .WIDTH (32)
   ) u_fifo (
      .clk       (clk),
      .rst_n     (rst_n),
      .push      (fifo_push),
      .push_data (enc_word),
      .pop       (fifo_pop),
      .head      (fifo_head),
      .full      (fifo_full),
      .empty     (fifo_empty),
      .level     (level)
   );

   // A new illegal accept takes priority over a clear in the same cycle.
   always_comb begin
      err_next = err_reg;
      if (err_set) begin
         err_next = 1'b1;
      end else if (err_clr) begin
         err_next = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         err_reg <= 1'b0;
      end else begin
         err_reg <= err_next;
      end
   end

   assign err_illegal = err_reg;

`ifdef INSTR_ENC_NOP_PAD_EN

   typedef enum logic {
      ST_ISSUE,
      ST_PAD
   } state_e;

   localparam logic [3:0] GAP_LOAD = 4'(NOP_GAP);

   state_e     state_reg;
   state_e     state_next;
   logic [3:0] gap_reg;
   logic [3:0] gap_next;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg <= ST_ISSUE;
         gap_reg   <= '0;
      end else begin
         state_reg <= state_next;
         gap_reg   <= gap_next;
      end
   end

   // While padding, the FIFO head is held back and NOPs are offered instead.
   always_comb begin
      state_next  = state_reg;
      gap_next    = gap_reg;
      fifo_pop    = 1'b0;
      instr_valid = 1'b0;
      instr       = '0;
      case (state_reg)
         ST_ISSUE: begin
            instr_valid = !fifo_empty;
            instr       = fifo_empty ? 32'h0 : fifo_head;
            if (!fifo_empty && instr_ready) begin
               fifo_pop = 1'b1;
               if (is_vec_arith(fifo_head[OP_MSB:OP_LSB])) begin
                  state_next = ST_PAD;
                  gap_next   = GAP_LOAD;
               end
            end
         end
         ST_PAD: begin
            instr_valid = 1'b1;
            instr       = NOP_WORD;
            if (instr_ready) begin
               gap_next = gap_reg - 4'd1;
               if (gap_reg == 4'd1) begin
                  state_next = ST_ISSUE;
               end
            end
         end
         default: begin
            state_next = ST_ISSUE;
         end
      endcase
   end

`else

   // Without padding the port is a plain view of the FIFO head.
   always_comb begin
      instr_valid = !fifo_empty;
      instr       = fifo_empty ? 32'h0 : fifo_head;
      fifo_pop    = !fifo_empty && instr_ready;
   end

   // NOP_GAP has no effect in this build; the empty block only keeps it referenced.
   if (NOP_GAP < 1) begin : g_nop_gap_unused
   end

`endif

endmodule
